// File: rtl/throw_meter.sv
// Charge-and-launch power meter: ramps power while the left button is held,
// then latches it with throw_flag until the projectile logic signals end_throw.
module throw_meter #(
  parameter int POWER_W   = 5,
  parameter int TICK_DIV  = 1880000,
  parameter int PINGPONG  = 0,
  parameter int MIN_POWER = 1
) (
  input  logic               clk40MHz,
  input  logic               rst,
  input  logic               left,
  input  logic               turn,
  input  logic               current_player,
  input  logic               end_throw,
  output logic [POWER_W-1:0] power,
  output logic               throw_flag,
  output logic               charging,
  output logic               at_max
);

  localparam int                 CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [POWER_W-1:0] PMAX     = '1;
  localparam logic [POWER_W-1:0] MIN_P    = POWER_W'(MIN_POWER);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CHARGE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [POWER_W-1:0] power_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic               dir, dir_n;
  logic               armed, armed_n;
  logic               tick;

  always_comb begin
    state_n = state;
    power_n = power;
    cnt_n   = cnt;
    dir_n   = dir;
    armed_n = armed;
    tick    = (cnt == CNT_LAST);

    case (state)
      S_WAIT: begin
        power_n = '0;
        cnt_n   = '0;
        dir_n   = 1'b1;
        if (!left) begin
          armed_n = 1'b1;
        end else if (armed && (turn == current_player)) begin
          state_n = S_CHARGE;
          armed_n = 1'b0;
        end
      end

      S_CHARGE: begin
        // Turn loss beats release, release beats tick: a release on a tick
        // cycle launches the power held before the tick.
        if (turn != current_player) begin
          state_n = S_WAIT;
          power_n = '0;
          cnt_n   = '0;
          dir_n   = 1'b1;
        end else if (!left) begin
          cnt_n = '0;
          if (power >= MIN_P) begin
            state_n = S_HOLD;
          end else begin
            state_n = S_WAIT;
            power_n = '0;
          end
        end else if (tick) begin
          cnt_n = '0;
          if (PINGPONG != 0) begin
            if (dir) begin
              if (power == PMAX) begin
                dir_n   = 1'b0;
                power_n = PMAX - POWER_W'(1);
              end else begin
                power_n = power + POWER_W'(1);
              end
            end else begin
              if (power == '0) begin
                dir_n   = 1'b1;
                power_n = POWER_W'(1);
              end else begin
                power_n = power - POWER_W'(1);
              end
            end
          end else if (power != PMAX) begin
            power_n = power + POWER_W'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      S_HOLD: begin
        if (end_throw) begin
          state_n = S_WAIT;
          power_n = '0;
        end
      end

      default: begin
        state_n = S_WAIT;
        power_n = '0;
        cnt_n   = '0;
        dir_n   = 1'b1;
        armed_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT;
      power      <= '0;
      cnt        <= '0;
      dir        <= 1'b1;
      armed      <= 1'b0;
      throw_flag <= 1'b0;
      charging   <= 1'b0;
      at_max     <= 1'b0;
    end else begin
      state      <= state_n;
      power      <= power_n;
      cnt        <= cnt_n;
      dir        <= dir_n;
      armed      <= armed_n;
      throw_flag <= (state_n == S_HOLD);
      charging   <= (state_n == S_CHARGE);
      at_max     <= (state_n == S_CHARGE) && (power_n == PMAX);
    end
  end

endmodule
